uart_num_parser: RTL and testbench

UART_NUM_PARSER -- requirements
Module: uart_num_parser

---
 rtl/uart_num_parser.sv | 143 ++++++++++++++
 tb/tb_uart_num_parser.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_num_parser.sv
// Parses decimal ASCII tokens from a UART byte stream into WIDTH-bit numbers.
// Optional feature: define UART_NUM_PARSER_NEG_EN to accept a leading '-' (two's complement output).
module uart_num_parser #(
    parameter int WIDTH   = 16,
    parameter int MAX_VAL = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [WIDTH-1:0] num_value,
    output logic             num_valid,
    input  logic             num_ready,
    output logic             err_pulse,
    output logic             overrun
);

    // Four spare bits keep acc*10+9 from wrapping, so the overflow compare is exact.
    localparam int ACC_W = WIDTH + 4;
    localparam logic [ACC_W-1:0] MAX_ACC = ACC_W'(MAX_VAL);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
`ifdef UART_NUM_PARSER_NEG_EN
    logic             neg;
    logic             has_digit;
    logic             is_minus;
`endif

    logic             is_digit;
    logic             is_delim;
    logic [ACC_W-1:0] digit;
    logic [ACC_W-1:0] acc_step;
    logic             acc_over;
    logic             token_done;
    logic             accept;
    logic [WIDTH-1:0] result;

    always_comb begin
        is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
        is_delim = (rx_data == 8'h20) || (rx_data == 8'h0D) ||
                   (rx_data == 8'h0A) || (rx_data == 8'h2C);
        digit    = {{(ACC_W-4){1'b0}}, rx_data[3:0]};
        acc_step = (acc << 3) + (acc << 1) + digit;
        acc_over = acc_step > MAX_ACC;
        accept   = num_valid && num_ready;
`ifdef UART_NUM_PARSER_NEG_EN
        is_minus   = (rx_data == 8'h2D);
        token_done = rx_valid && (state == ACCUM) && is_delim && has_digit;
        result     = neg ? (WIDTH'(0) - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
`else
        token_done = rx_valid && (state == ACCUM) && is_delim;
        result     = acc[WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            num_value <= '0;
            num_valid <= 1'b0;
            err_pulse <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_NUM_PARSER_NEG_EN
            neg       <= 1'b0;
            has_digit <= 1'b0;
`endif
        end else begin
            err_pulse <= 1'b0;

            // Output holding register: a completion while the consumer stalls is lost.
            if (token_done) begin
                if (!num_valid || num_ready) begin
                    num_value <= result;
                    num_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (accept) begin
                num_valid <= 1'b0;
            end

            if (rx_valid) begin
                case (state)
                    IDLE: begin
                        if (is_digit) begin
                            acc   <= digit;
                            state <= ACCUM;
`ifdef UART_NUM_PARSER_NEG_EN
                            neg       <= 1'b0;
                            has_digit <= 1'b1;
                        end else if (is_minus) begin
                            acc       <= '0;
                            neg       <= 1'b1;
                            has_digit <= 1'b0;
                            state     <= ACCUM;
`endif
                        end else if (!is_delim) begin
                            err_pulse <= 1'b1;
                            state     <= DROP;
                        end
                    end
                    ACCUM: begin
                        if (is_digit) begin
                            if (acc_over) begin
                                err_pulse <= 1'b1;
                                state     <= DROP;
                            end else begin
                                acc <= acc_step;
`ifdef UART_NUM_PARSER_NEG_EN
                                has_digit <= 1'b1;
`endif
                            end
                        end else if (is_delim) begin
                            state <= IDLE;
`ifdef UART_NUM_PARSER_NEG_EN
                            // A bare '-' is a malformed token.
                            if (!has_digit)
                                err_pulse <= 1'b1;
`endif
                        end else begin
                            err_pulse <= 1'b1;
                            state     <= DROP;
                        end
                    end
                    DROP: begin
                        if (is_delim)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_num_parser.sv
// Scoreboard bench for uart_num_parser: expected numbers and error cycles are queued per token.
module tb_uart_num_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [15:0] num_value;
    logic        num_valid;
    logic        num_ready = 1'b1;
    logic        err_pulse;
    logic        overrun;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int exp_val_q[$];
    int exp_due_q[$];
    int err_due_q[$];

    uart_num_parser #(.WIDTH(16), .MAX_VAL(65535)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .num_value (num_value),
        .num_valid (num_valid),
        .num_ready (num_ready),
        .err_pulse (err_pulse),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Accepted outputs and error pulses are popped from the scoreboard as they appear.
    always @(negedge clk) begin
        if (!rst) begin
            if (num_valid && num_ready) begin
                if (exp_val_q.size() == 0) begin
                    check_val("unexpected_out", num_valid, 1'b0);
                end else begin
                    int v;
                    int d;
                    v = exp_val_q.pop_front();
                    d = exp_due_q.pop_front();
                    check_val("out_value", num_value, v);
                    if (d >= 0)
                        check_val("out_cycle", cyc, d);
                end
            end
            if (err_pulse) begin
                if (err_due_q.size() == 0)
                    check_val("unexpected_err", err_pulse, 1'b0);
                else
                    check_val("err_cycle", cyc, err_due_q.pop_front());
            end
        end
    end

    // out_mode: 0 no output, 1 output one cycle after the last byte, 2 output at an unchecked time.
    task automatic send_tok(input string s, input int out_mode, input int val, input int err_idx);
        $display("[TB] token \"%s\" out_mode=%0d value=0x%0h err_idx=%0d", s, out_mode, val, err_idx);
        for (int i = 0; i < s.len(); i++) begin
            rx_data  = s[i];
            rx_valid = 1'b1;
            if (i == err_idx)
                err_due_q.push_back(cyc + 1);
            if (i == s.len() - 1 && out_mode != 0) begin
                exp_val_q.push_back(val);
                exp_due_q.push_back(out_mode == 1 ? cyc + 1 : -1);
            end
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_drained(input string tag);
        idle_cycles(3);
        check_val({tag, "_outq"}, exp_val_q.size(), 0);
        check_val({tag, "_errq"}, err_due_q.size(), 0);
        exp_val_q.delete();
        exp_due_q.delete();
        err_due_q.delete();
    endtask

    initial begin
        #2;
        check_val("rst_value", num_value, 16'h0);
        check_val("rst_valid", num_valid, 1'b0);
        check_val("rst_err", err_pulse, 1'b0);
        check_val("rst_overrun", overrun, 1'b0);
        idle_cycles(2);
        rst = 1'b0;
        idle_cycles(1);

        send_tok("10 ", 1, 10, -1);
        send_tok("20 ", 1, 20, -1);
        check_drained("basic");

        send_tok("65535 ", 1, 65535, -1);
        send_tok("65536 ", 0, 0, 4);
        send_tok("3 ", 1, 3, -1);
        send_tok("99999 ", 0, 0, 4);
        send_tok("0 ", 1, 0, -1);
        check_drained("maxval");

        send_tok("1a2 ", 0, 0, 1);
        send_tok("5 ", 1, 5, -1);
        send_tok("x!! ", 0, 0, 0);
        send_tok("1a!!b ", 0, 0, 1);
        check_drained("malformed");

        send_tok("007,", 1, 7, -1);
        send_tok("\r\n, ", 0, 0, -1);
        send_tok("8\r", 1, 8, -1);
        send_tok("4\n", 1, 4, -1);
        check_drained("delims");

`ifdef UART_NUM_PARSER_NEG_EN
        send_tok("-5 ", 1, 16'hFFFB, -1);
        send_tok("- ", 0, 0, 1);
        send_tok("3-4 ", 0, 0, 1);
        send_tok("-0 ", 1, 0, -1);
`else
        send_tok("-5 ", 0, 0, 0);
`endif
        send_tok("6 ", 1, 6, -1);
        check_drained("minus");

        num_ready = 1'b0;
        send_tok("7 ", 2, 7, -1);
        send_tok("8 ", 0, 0, -1);
        idle_cycles(1);
        check_val("hold_valid", num_valid, 1'b1);
        check_val("hold_value", num_value, 16'd7);
        check_val("overrun_set", overrun, 1'b1);
        num_ready = 1'b1;
        idle_cycles(1);
        check_val("valid_drop", num_valid, 1'b0);
        check_val("overrun_sticky", overrun, 1'b1);
        check_drained("overrun");

        num_ready = 1'b0;
        send_tok("1 ", 2, 1, -1);
        send_tok("2", 0, 0, -1);
        num_ready = 1'b1;
        send_tok(" ", 1, 2, -1);
        check_drained("accept_load");

        num_ready = 1'b0;
        send_tok("9 ", 0, 0, -1);
        send_tok("12", 0, 0, -1);
        rst = 1'b1;
        #1;
        check_val("mid_rst_value", num_value, 16'h0);
        check_val("mid_rst_valid", num_valid, 1'b0);
        check_val("mid_rst_err", err_pulse, 1'b0);
        check_val("mid_rst_overrun", overrun, 1'b0);
        idle_cycles(2);
        rst = 1'b0;
        num_ready = 1'b1;
        send_tok("34 ", 1, 34, -1);
        check_drained("reset");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
